// File: rtl/pq_host_if.sv
// Command, response and device-side signal bundle between a traffic source,
// the pq_host protocol engine and a priority-queue device.
interface pq_host_if #(
    parameter int KV_W = 32
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [KV_W-1:0] cmd_kv;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [KV_W-1:0] rsp_kv;
    logic            pq_enq;
    logic            pq_deq;
    logic [KV_W-1:0] pq_kvi;
    logic [KV_W-1:0] pq_kvo;

    modport slave (
        input  cmd_valid, cmd_op, cmd_kv, rsp_ready, pq_kvo,
        output cmd_ready, rsp_valid, rsp_kv, pq_enq, pq_deq, pq_kvi
    );

    modport master (
        output cmd_valid, cmd_op, cmd_kv, rsp_ready, pq_kvo,
        input  cmd_ready, rsp_valid, rsp_kv, pq_enq, pq_deq, pq_kvi
    );
endinterface

// File: rtl/pq_host.sv
// Host-side protocol engine for a hardware priority queue: sequences enq/deq
// strobes with the device's operation gap, tracks occupancy, returns dequeued pairs.
module pq_host #(
    parameter int  CAPACITY = 15,
    parameter int  KEY_W    = 16,
    parameter int  VAL_W    = 16,
    parameter int  OP_LAT   = 2,
    localparam int CW       = $clog2(CAPACITY + 1),
    localparam int KV_W     = KEY_W + VAL_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    pq_host_if.slave      bus,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_err_ovf,
    output logic          o_err_udf
);

    localparam logic [1:0]    OP_ENQ   = 2'd1;
    localparam logic [1:0]    OP_DEQ   = 2'd2;
    localparam logic [1:0]    OP_REP   = 2'd3;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_CAP  = CW'(CAPACITY);
    localparam logic [3:0]    GAP_LOAD = 4'(OP_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [1:0]      r_op;
    logic [3:0]      r_gap;
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_err_ovf;
    logic            r_err_udf;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [KV_W-1:0] r_rsp_kv;
    logic            r_enq;
    logic            r_deq;
    logic [KV_W-1:0] r_kvi;

    logic            w_accept;
    logic            w_rsp_hold;
    logic [CW-1:0]   w_count_inc;
    logic [CW-1:0]   w_count_dec;
    logic            w_go;
    logic            w_ovf;
    logic            w_udf;
    logic [1:0]      w_eff_op;

    assign w_accept    = bus.cmd_valid && r_cmd_ready && (r_state == ST_IDLE);
    assign w_rsp_hold  = r_rsp_valid && !bus.rsp_ready;
    assign w_count_inc = r_count + CNT_ONE;
    assign w_count_dec = r_count - CNT_ONE;

    // Classify the offered command against current occupancy; REPLACE on empty degrades to ENQ.
    always_comb begin
        w_go     = 1'b0;
        w_ovf    = 1'b0;
        w_udf    = 1'b0;
        w_eff_op = bus.cmd_op;
        case (bus.cmd_op)
            OP_ENQ: begin
                if (r_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_go = 1'b1;
                end
            end
            OP_DEQ: begin
                if (r_empty) begin
                    w_udf = 1'b1;
                end else begin
                    w_go = 1'b1;
                end
            end
            OP_REP: begin
                w_go = 1'b1;
                if (r_empty) begin
                    w_eff_op = OP_ENQ;
                end else begin
                    w_eff_op = OP_REP;
                end
            end
            default: begin
                w_go = 1'b0;
            end
        endcase
    end

    // Protocol FSM with all host outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_op        <= 2'd0;
            r_gap       <= 4'd0;
            r_count     <= CNT_ZERO;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_err_ovf   <= 1'b0;
            r_err_udf   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_kv    <= '0;
            r_enq       <= 1'b0;
            r_deq       <= 1'b0;
            r_kvi       <= '0;
        end else begin
            if (r_rsp_valid && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end else begin
                r_rsp_valid <= r_rsp_valid;
            end
            case (r_state)
                ST_IDLE: begin
                    r_enq <= 1'b0;
                    r_deq <= 1'b0;
                    if (w_accept && w_go) begin
                        r_state     <= ST_ISSUE;
                        r_op        <= w_eff_op;
                        r_kvi       <= bus.cmd_kv;
                        r_enq       <= (w_eff_op != OP_DEQ);
                        r_deq       <= (w_eff_op != OP_ENQ);
                        r_cmd_ready <= 1'b0;
                    end else if (w_accept) begin
                        r_err_ovf   <= r_err_ovf | w_ovf;
                        r_err_udf   <= r_err_udf | w_udf;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_cmd_ready <= !w_rsp_hold;
                    end
                end
                ST_ISSUE: begin
                    r_enq <= 1'b0;
                    r_deq <= 1'b0;
                    // pq_kvo is sampled on the same edge the device consumes the strobe.
                    case (r_op)
                        OP_ENQ: begin
                            r_count <= w_count_inc;
                            r_full  <= (w_count_inc == CNT_CAP);
                            r_empty <= 1'b0;
                        end
                        OP_DEQ: begin
                            r_count     <= w_count_dec;
                            r_full      <= 1'b0;
                            r_empty     <= (w_count_dec == CNT_ZERO);
                            r_rsp_valid <= 1'b1;
                            r_rsp_kv    <= bus.pq_kvo;
                        end
                        OP_REP: begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_kv    <= bus.pq_kvo;
                        end
                        default: begin
                            r_count <= r_count;
                        end
                    endcase
                    if (OP_LAT == 1) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= (r_op == OP_ENQ);
                    end else begin
                        r_state     <= ST_WAIT;
                        r_gap       <= GAP_LOAD;
                        r_cmd_ready <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_gap <= 4'd1) begin
                        r_state     <= ST_IDLE;
                        r_gap       <= 4'd0;
                        r_cmd_ready <= !w_rsp_hold;
                    end else begin
                        r_gap       <= r_gap - 4'd1;
                        r_cmd_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_enq       <= 1'b0;
                    r_deq       <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_kv    = r_rsp_kv;
    assign bus.pq_enq    = r_enq;
    assign bus.pq_deq    = r_deq;
    assign bus.pq_kvi    = r_kvi;
    assign o_count       = r_count;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_err_ovf     = r_err_ovf;
    assign o_err_udf     = r_err_udf;

endmodule

// File: tb/tb_pq_host.sv
// Self-checking bench for pq_host: a behavioural min-queue device, a response
// scoreboard, and extra OP_LAT=1/4 instances for strobe spacing.
module tb_pq_host;

    localparam logic [1:0] OP_ENQ = 2'd1;
    localparam logic [1:0] OP_DEQ = 2'd2;
    localparam logic [1:0] OP_REP = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_kv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pq_host_if #(.KV_W(32)) bus ();
    pq_host_if #(.KV_W(32)) bus1 ();
    pq_host_if #(.KV_W(32)) bus4 ();

    logic [3:0] count, count1, count4;
    logic full, empty, err_ovf, err_udf;
    logic full1, empty1, ovf1, udf1, full4, empty4, ovf4, udf4;

    pq_host #(.OP_LAT(2)) u_dut (.i_clk(clk), .i_rst(rst), .bus(bus), .o_count(count),
        .o_full(full), .o_empty(empty), .o_err_ovf(err_ovf), .o_err_udf(err_udf));
    pq_host #(.OP_LAT(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1), .o_count(count1),
        .o_full(full1), .o_empty(empty1), .o_err_ovf(ovf1), .o_err_udf(udf1));
    pq_host #(.OP_LAT(4)) u_dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4), .o_count(count4),
        .o_full(full4), .o_empty(empty4), .o_err_ovf(ovf4), .o_err_udf(udf4));

    assign bus1.cmd_op = OP_ENQ;
    assign bus1.cmd_kv = 32'h0001_0001;
    assign bus1.rsp_ready = 1'b1;
    assign bus1.pq_kvo = 32'h0;
    assign bus4.cmd_op = OP_ENQ;
    assign bus4.cmd_kv = 32'h0001_0001;
    assign bus4.rsp_ready = 1'b1;
    assign bus4.pq_kvo = 32'h0;

    // Behavioural device: unordered slots, combinational minimum on pq_kvo.
    logic [31:0] dmem [16];
    logic [15:0] dval;
    logic [3:0]  min_idx, free_idx;
    logic [31:0] min_kv;
    logic        found;

    always_comb begin
        min_idx = 4'd0;
        free_idx = 4'd0;
        min_kv = 32'hFFFF_FFFF;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (dval[i] && (!found || dmem[i][31:16] < min_kv[31:16])) begin
                min_kv = dmem[i];
                min_idx = 4'(i);
                found = 1'b1;
            end
        end
        for (int j = 15; j >= 0; j--) begin
            if (!dval[j]) free_idx = 4'(j);
        end
    end
    assign bus.pq_kvo = min_kv;

    always @(posedge clk) begin
        if (!rst) begin
            dval <= 16'h0;
        end else if (bus.pq_enq && bus.pq_deq) begin
            dmem[min_idx] <= bus.pq_kvi;
        end else if (bus.pq_enq) begin
            dmem[free_idx] <= bus.pq_kvi;
            dval[free_idx] <= 1'b1;
        end else if (bus.pq_deq) begin
            dval[min_idx] <= 1'b0;
        end
    end

    // Scoreboard: every response handshake must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst && bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got %08h exp none", bus.rsp_kv);
            end else begin
                exp_kv = exp_q.pop_front();
                if (bus.rsp_kv !== exp_kv) begin
                    errors++;
                    $display("FAIL rsp_kv got %08h exp %08h", bus.rsp_kv, exp_kv);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] kv);
        int n;
        bus.cmd_op = op;
        bus.cmd_kv = kv;
        bus.cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout cmd_ready=%0b exp 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout cmd_ready=%0b exp 1", bus.cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.pq_enq, bus.pq_deq} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %04b exp 0000", {bus.cmd_ready, bus.rsp_valid, bus.pq_enq, bus.pq_deq});
        end
        checks++;
        if ({bus.rsp_kv, bus.pq_kvi} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %08h %08h exp 0 0", bus.rsp_kv, bus.pq_kvi);
        end
        checks++;
        if ({count, full, empty, err_ovf, err_udf} !== 8'b0000_0100) begin
            errors++;
            $display("FAIL reset_status got %08b exp 00000100", {count, full, empty, err_ovf, err_udf});
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_order();
        send(OP_ENQ, 32'h0005_0050);
        send(OP_ENQ, 32'h0003_0030);
        send(OP_ENQ, 32'h0009_0090);
        wait_idle();
        checks++;
        if (count !== 4'd3) begin errors++; $display("FAIL order_count3 got %0d exp 3", count); end
        @(posedge clk); #1;
        exp_q.push_back(32'h0003_0030);
        send(OP_DEQ, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.pq_enq, bus.pq_deq} !== 2'b01) begin
            errors++;
            $display("FAIL deq_strobe got %02b exp 01", {bus.pq_enq, bus.pq_deq});
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || count !== 4'd2) begin
            errors++;
            $display("FAIL deq_rsp_timing got valid=%0b count=%0d exp 1 2", bus.rsp_valid, count);
        end
        @(posedge clk); #1;
        exp_q.push_back(32'h0005_0050);
        send(OP_DEQ, 32'h0);
        exp_q.push_back(32'h0009_0090);
        send(OP_DEQ, 32'h0);
        wait_idle();
        checks++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL order_drained got count=%0d empty=%0b exp 0 1", count, empty);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_replace();
        send(OP_ENQ, 32'h0007_0070);
        exp_q.push_back(32'h0007_0070);
        send(OP_REP, 32'h0002_0020);
        @(negedge clk);
        checks++;
        if ({bus.pq_enq, bus.pq_deq} !== 2'b11 || bus.pq_kvi !== 32'h0002_0020) begin
            errors++;
            $display("FAIL rep_strobe got %02b kvi=%08h exp 11 00020020", {bus.pq_enq, bus.pq_deq}, bus.pq_kvi);
        end
        wait_idle();
        checks++;
        if (count !== 4'd1) begin errors++; $display("FAIL rep_count got %0d exp 1", count); end
        @(posedge clk); #1;
        exp_q.push_back(32'h0002_0020);
        send(OP_DEQ, 32'h0);
        wait_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_underflow();
        send(OP_DEQ, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.pq_deq, err_udf, bus.cmd_ready, bus.rsp_valid} !== 4'b0110) begin
            errors++;
            $display("FAIL udf got deq/udf/rdy/rsp=%04b exp 0110", {bus.pq_deq, err_udf, bus.cmd_ready, bus.rsp_valid});
        end
        @(posedge clk); #1;
        send(OP_REP, 32'h0004_0040);
        @(negedge clk);
        checks++;
        if ({bus.pq_enq, bus.pq_deq} !== 2'b10) begin
            errors++;
            $display("FAIL rep_empty_strobe got %02b exp 10", {bus.pq_enq, bus.pq_deq});
        end
        wait_idle();
        checks++;
        if (count !== 4'd1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rep_empty got count=%0d rsp=%0b exp 1 0", count, bus.rsp_valid);
        end
        @(posedge clk); #1;
        exp_q.push_back(32'h0004_0040);
        send(OP_DEQ, 32'h0);
        wait_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 15; i++) send(OP_ENQ, {16'(100 + i), 16'(i)});
        wait_idle();
        checks++;
        if (count !== 4'd15 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill got count=%0d full=%0b exp 15 1", count, full);
        end
        @(posedge clk); #1;
        send(OP_ENQ, 32'h0000_0001);
        @(negedge clk);
        checks++;
        if ({bus.pq_enq, err_ovf, full, bus.cmd_ready} !== 4'b0111 || count !== 4'd15) begin
            errors++;
            $display("FAIL ovf got enq/ovf/full/rdy=%04b count=%0d exp 0111 15",
                     {bus.pq_enq, err_ovf, full, bus.cmd_ready}, count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rsp_stall();
        bus.rsp_ready = 1'b0;
        exp_q.push_back(32'h0064_0000);
        send(OP_DEQ, 32'h0);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_kv !== 32'h0064_0000 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall cyc%0d got valid=%0b kv=%08h rdy=%0b exp 1 00640000 0",
                         k, bus.rsp_valid, bus.rsp_kv, bus.cmd_ready);
            end
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || count !== 4'd14) begin
            errors++;
            $display("FAIL stall_release got valid=%0b rdy=%0b count=%0d exp 0 1 14",
                     bus.rsp_valid, bus.cmd_ready, count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready = 1'b0;
        send(OP_DEQ, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.pq_enq, bus.pq_deq} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_strobes got %04b exp 0000", {bus.cmd_ready, bus.rsp_valid, bus.pq_enq, bus.pq_deq});
        end
        checks++;
        if ({count, full, empty, err_ovf, err_udf} !== 8'b0000_0100 || bus.rsp_kv !== 32'h0) begin
            errors++;
            $display("FAIL midrst_status got %08b kv=%08h exp 00000100 0",
                     {count, full, empty, err_ovf, err_udf}, bus.rsp_kv);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int f2 = -1, s2 = -1, f1 = -1, s1 = -1, f4 = -1, s4 = -1;
        bus.cmd_op = OP_ENQ;
        bus.cmd_kv = 32'h0001_0001;
        bus.cmd_valid = 1'b1;
        bus1.cmd_valid = 1'b1;
        bus4.cmd_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.pq_enq) begin if (f2 < 0) f2 = cyc; else if (s2 < 0) s2 = cyc; end
            if (bus1.pq_enq) begin if (f1 < 0) f1 = cyc; else if (s1 < 0) s1 = cyc; end
            if (bus4.pq_enq) begin if (f4 < 0) f4 = cyc; else if (s4 < 0) s4 = cyc; end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus1.cmd_valid = 1'b0;
        bus4.cmd_valid = 1'b0;
        checks++;
        if (f2 < 0 || s2 - f2 != 3) begin errors++; $display("FAIL spacing_lat2 got %0d exp 3", s2 - f2); end
        checks++;
        if (f1 < 0 || s1 - f1 != 2) begin errors++; $display("FAIL spacing_lat1 got %0d exp 2", s1 - f1); end
        checks++;
        if (f4 < 0 || s4 - f4 != 5) begin errors++; $display("FAIL spacing_lat4 got %0d exp 5", s4 - f4); end
        wait_idle();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'd0;
        bus.cmd_kv = 32'h0;
        bus.rsp_ready = 1'b1;
        bus1.cmd_valid = 1'b0;
        bus4.cmd_valid = 1'b0;
        test_reset();
        test_order();
        test_replace();
        test_underflow();
        test_overflow();
        test_rsp_stall();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
